sccb_arbiter: RTL
=================

SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, cycles to wait for sccb_done before abort (only with timeout compiled in).
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester write request, held high until that requester's ack or err.
REQ-006 SHALL have port req_addr  input  8*NUM_REQ  register address; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_data  input  8*NUM_REQ  register data, packed like req_addr.
REQ-008 SHALL have port ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-010 SHALL have port grant  output  NUM_REQ  one-hot owner of the SCCB master; all zero when idle.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have ports sccb_start (output, 1), sccb_addr (output, 8), sccb_data (output, 8), sccb_done (input, 1) to the SCCB master.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE with req nonzero, SHALL pick a winner round-robin starting at index rr_ptr, latch its addr/data into sccb_addr/sccb_data, set grant one-hot, go to ISSUE.
REQ-015 In IDLE with req zero, SHALL stay in IDLE with grant zero.
REQ-016 ISSUE SHALL drive sccb_start high for exactly one cycle, then go to WAIT.
REQ-017 Latency: req sampled in IDLE at edge N gives sccb_start high in the cycle after edge N+1.
REQ-018 In WAIT, sccb_done sampled high SHALL go to RESP; sccb_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-019 RESP SHALL pulse ack[winner] for one cycle, clear grant, set rr_ptr = (winner+1) mod NUM_REQ, go to IDLE.
REQ-020 sccb_addr/sccb_data SHALL hold stable from ISSUE through RESP regardless of req_addr/req_data changes.
REQ-021 A winner dropping req before completion SHALL NOT abort the transaction; ack still pulses.
REQ-022 Requests arriving while busy SHALL wait; none is lost while its req stays high.
REQ-023 With all NUM_REQ requesting continuously, each SHALL be served once per NUM_REQ transactions.
REQ-024 ack and err SHALL never be high in the same cycle; at most one bit of either is high.

Reset
REQ-025 rst high SHALL force state IDLE, rr_ptr 0, and sccb_start, sccb_addr, sccb_data, grant, ack, err, busy, timeout counter all 0, immediately.
REQ-026 Reset mid-transaction SHALL abandon it with no ack/err; after release, first grant follows REQ-014 from rr_ptr 0.

Configuration
REQ-027 Macro SCCB_ARB_TIMEOUT_EN defined: counter clears on entering WAIT and increments each WAIT cycle; reaching TIMEOUT_CYCLES without sccb_done SHALL pulse err[winner], clear grant, advance rr_ptr, return to IDLE; sccb_done in that same cycle wins (ack, no err).
REQ-028 Macro SCCB_ARB_TIMEOUT_EN undefined: SHALL wait in WAIT indefinitely; err tied 0; no counter logic.

Structure
REQ-029 Shared package sccb_arb_pkg SHALL hold the state encoding, SCCB address/data width (8) and default TIMEOUT_CYCLES.
REQ-030 Round-robin selection SHALL live in sub-module rr_priority_picker (combinational: req, rr_ptr -> one-hot winner plus index).

Verification
REQ-031 Reset release, req=4'b0010, addr 8'h12 data 8'h04 on index 1 -> sccb_start one pulse with sccb_addr 8'h12, sccb_data 8'h04; sccb_done 10 cycles later -> ack=4'b0010 one cycle, busy low next cycle.
REQ-032 req=4'b1111 held, done 5 cycles after each start -> grant order 0,1,2,3,0.
REQ-033 After grant to 2, req[2] drops, req_addr[2] changes to 8'hFF -> sccb_addr stays original, ack[2] still pulses.
REQ-034 sccb_done pulsed in IDLE and in ISSUE -> no state change, no ack; transaction completes only on later done in WAIT.
REQ-035 Timeout enabled, TIMEOUT_CYCLES=16, no sccb_done -> err[winner] pulses after 16 WAIT cycles, ack stays 0, next requester granted.
REQ-036 rst asserted during WAIT -> all outputs 0 same cycle; after release req=4'b1000 -> grant 4'b1000 with no stale ack.

Source files
------------

// File: rtl/sccb_arb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_arb_pkg
// Shared definitions for the SCCB write arbiter: FSM state encoding, the SCCB
// register address/data width and the default abort timeout in clock cycles.
// -----------------------------------------------------------------------------
package sccb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int SCCB_DW              = 8;
  localparam int SCCB_TIMEOUT_DEFAULT = 65535;

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selector. The scan starts at rr_ptr and wraps
// around modulo N. The first active request found is the winner.
// Ports:
//   req        in  [N-1:0]          active requests
//   rr_ptr     in  [clog2(N)-1:0]   highest-priority index this round
//   winner_oh  out [N-1:0]          one-hot winner (zero when req is zero)
//   winner_idx out [clog2(N)-1:0]   binary winner index
//   valid      out                  any request present
// -----------------------------------------------------------------------------
module rr_priority_picker
  import sccb_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         winner_oh,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  // Scan from farthest to nearest offset so the nearest active request wins
  always_comb begin
    int unsigned pos;
    logic [IW-1:0] pos_idx;
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = 32'(rr_ptr) + 32'(k);
      if (pos >= 32'(N)) begin
        pos = pos - 32'(N);
      end else begin
        pos = pos;
      end
      pos_idx = IW'(pos);
      if (req[pos_idx]) begin
        winner_oh          = '0;
        winner_oh[pos_idx] = 1'b1;
        winner_idx         = pos_idx;
        valid              = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_arbiter
// Round-robin arbiter that shares one SCCB master among NUM_REQ register-write
// requesters. The FSM runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE. The winner's
// address and data are latched when the grant is issued, so requesters may
// change or drop their inputs once they are granted.
// Optional feature: define SCCB_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles with an err pulse. When it is undefined, WAIT waits
// indefinitely and err stays 0.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req[NUM_REQ]          write requests, held until ack/err
//   req_addr/req_data     8 bits per requester, requester i at [8i+7:8i]
//   ack/err[NUM_REQ]      one-cycle completion / timeout pulse to the winner
//   grant[NUM_REQ]        one-hot owner of the SCCB master
//   busy                  FSM not in IDLE
//   sccb_start/addr/data  command to the SCCB master; sccb_done = its completion
// -----------------------------------------------------------------------------
module sccb_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = SCCB_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [SCCB_DW*NUM_REQ-1:0]   req_addr,
  input  logic [SCCB_DW*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           err,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         sccb_start,
  output logic [SCCB_DW-1:0]           sccb_addr,
  output logic [SCCB_DW-1:0]           sccb_data,
  input  logic                         sccb_done
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic                start_q, start_d;
  logic [SCCB_DW-1:0]  addr_q, addr_d;
  logic [SCCB_DW-1:0]  data_q, data_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  pick_oh_s;
  logic [IW-1:0]       pick_idx_s;
  logic                pick_vld_s;
  logic                timeout_s;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (pick_oh_s),
    .winner_idx (pick_idx_s),
    .valid      (pick_vld_s)
  );

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Count WAIT cycles; the counter is zero in every other state
  always_comb begin
    if (state_q == ST_WAIT) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end else begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle
  assign timeout_s = (state_q == ST_WAIT) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and output logic of the arbitration FSM
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = '0;
    start_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          win_d   = pick_idx_s;
          grant_d = pick_oh_s;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh_s[i]) begin
              addr_d = req_addr[SCCB_DW*i +: SCCB_DW];
              data_d = req_data[SCCB_DW*i +: SCCB_DW];
            end else begin
              addr_d = addr_d;
            end
          end
          state_d = ST_ISSUE;
        end else begin
          grant_d = '0;
        end
      end
      // sccb_start is registered, so its pulse lands in the first WAIT cycle
      ST_ISSUE: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      // A done in the timeout cycle takes precedence over the abort
      ST_WAIT: begin
        if (sccb_done) begin
          ack_d   = grant_q;
          state_d = ST_RESP;
        end else if (timeout_s) begin
          err_d   = grant_q;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        grant_d  = '0;
        rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign sccb_start = start_q;
  assign sccb_addr  = addr_q;
  assign sccb_data  = data_q;

endmodule
